// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the core request/response handshake and the data-memory bus of the
//   load/store unit.
//   master : the load/store unit (drives req_ready, resp_*, memory strobes,
//            AddressBus and DataMemoryInput; receives the request and
//            DataMemoryOutput).
//   slave  : the environment (core + data memory), the mirror image.
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    // Core request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // Core response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    // Data memory bus
    logic        MemReadEn;
    logic        MemWriteEn;
    logic [31:0] AddressBus;
    logic [31:0] DataMemoryInput;
    logic [31:0] DataMemoryOutput;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, DataMemoryOutput,
        output req_ready, resp_valid, resp_rdata, resp_err,
               MemReadEn, MemWriteEn, AddressBus, DataMemoryInput
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, DataMemoryOutput,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               MemReadEn, MemWriteEn, AddressBus, DataMemoryInput
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Requester-side master for the byte-addressed data memory. Executes RV32I
//   LB/LH/LW/LBU/LHU/SB/SH/SW. The memory is always written a full word, so
//   SB/SH are read-modify-write. Loads are sign/zero-extended here.
// Ports
//   clock : single clock, all state changes on posedge
//   rst   : asynchronous active-low reset
//   bus   : load_store_unit_if.master (core handshake + data memory bus)
// Parameters
//   ADDR_BITS : memory index width; every address is masked to it
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_BITS = 10
) (
    input  logic                clock,
    input  logic                rst,
    load_store_unit_if.master   bus
);

    localparam logic [31:0] ADDR_MASK = (32'd1 << ADDR_BITS) - 32'd1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] merge_q;     // holds the store data until merged, then the write word
    logic [31:0] rdata_q;
    logic        err_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic        rd_en_q;
    logic        wr_en_q;

    logic        illegal_s;
    logic [31:0] merge_s;
    logic [31:0] load_ext_s;

    // Sign/zero extension of the raw memory word according to the load type.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {{24{d[7]}}, d[7:0]};
            F3_H:    r = {{16{d[15]}}, d[15:0]};
            F3_W:    r = d;
            F3_BU:   r = {24'd0, d[7:0]};
            F3_HU:   r = {16'd0, d[15:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Classify the incoming request as legal or illegal for its direction.
    always_comb begin
        illegal_s = 1'b0;
        if (bus.req_we) begin
            case (bus.req_funct3)
                F3_B, F3_H, F3_W: illegal_s = 1'b0;
                default:          illegal_s = 1'b1;
            endcase
        end else begin
            case (bus.req_funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_s = 1'b0;
                default:                        illegal_s = 1'b1;
            endcase
        end
    end

    // Merge the stored byte/half into the word just read; extend load data.
    always_comb begin
        merge_s    = merge_q;
        load_ext_s = load_extend(funct3_q, bus.DataMemoryOutput);
        case (funct3_q)
            F3_B:    merge_s = {bus.DataMemoryOutput[31:8],  merge_q[7:0]};
            F3_H:    merge_s = {bus.DataMemoryOutput[31:16], merge_q[15:0]};
            default: merge_s = merge_q;
        endcase
    end

    // Request FSM; strobes and handshake outputs are registered alongside the
    // state so each one is high exactly while its state is current.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            merge_q      <= 32'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr & ADDR_MASK;
                        merge_q  <= bus.req_wdata;
                        ready_q  <= 1'b0;
                        if (illegal_s) begin
                            // No memory access at all; report the error at once.
                            err_q        <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                            wr_en_q <= 1'b1;
                            state_q <= ST_WR;
                        end else begin
                            // Loads, and SB/SH which need the old word first.
                            rd_en_q <= 1'b1;
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (we_q) begin
                        merge_q <= merge_s;
                        wr_en_q <= 1'b1;
                        state_q <= ST_WR;
                    end else begin
                        rdata_q      <= load_ext_s;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    wr_en_q      <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    rdata_q      <= 32'd0;
                    err_q        <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet IDLE.
                    rd_en_q      <= 1'b0;
                    wr_en_q      <= 1'b0;
                    resp_valid_q <= 1'b0;
                    rdata_q      <= 32'd0;
                    err_q        <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = rdata_q;
    assign bus.resp_err        = err_q;
    assign bus.MemReadEn       = rd_en_q;
    assign bus.MemWriteEn      = wr_en_q;
    assign bus.AddressBus      = addr_q;
    assign bus.DataMemoryInput = merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Scoreboard bench: each request pushes its expected response; a negedge
//   monitor pops and compares whenever resp_valid is seen. A small byte memory
//   model (wrapping at 1024 bytes) serves the memory bus.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        string       name;
    } exp_t;

    logic clock;
    logic rst;
    load_store_unit_if bus();

    load_store_unit #(.ADDR_BITS(10)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    exp_t sb_q[$];
    exp_t exp_e;

    int cyc           = 0;
    int accept_edge   = 0;
    int last_resp_cyc = 0;
    int rd_cnt        = 0;
    int wr_cnt        = 0;
    logic [31:0] wr_addr_last = 32'd0;
    logic [31:0] wr_data_last = 32'd0;

    // Memory model
    logic [7:0]  mem [0:1023];
    logic [31:0] dout;
    logic        pl_en   = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [31:0] pl_word = 32'd0;

    assign bus.DataMemoryOutput = dout;

    always @(posedge clock) begin
        if (bus.MemReadEn)
            dout <= {mem[bus.AddressBus[9:0] + 10'd3], mem[bus.AddressBus[9:0] + 10'd2],
                     mem[bus.AddressBus[9:0] + 10'd1], mem[bus.AddressBus[9:0]]};
        if (bus.MemWriteEn) begin
            mem[bus.AddressBus[9:0]]         <= bus.DataMemoryInput[7:0];
            mem[bus.AddressBus[9:0] + 10'd1] <= bus.DataMemoryInput[15:8];
            mem[bus.AddressBus[9:0] + 10'd2] <= bus.DataMemoryInput[23:16];
            mem[bus.AddressBus[9:0] + 10'd3] <= bus.DataMemoryInput[31:24];
        end
        if (pl_en) begin
            mem[pl_addr]         <= pl_word[7:0];
            mem[pl_addr + 10'd1] <= pl_word[15:8];
            mem[pl_addr + 10'd2] <= pl_word[23:16];
            mem[pl_addr + 10'd3] <= pl_word[31:24];
        end
    end

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Edge counter and accept-edge capture
    always @(posedge clock) begin
        if (bus.req_valid && bus.req_ready)
            accept_edge <= cyc + 1;
        cyc <= cyc + 1;
    end

    // Monitor: strobe accounting and scoreboard compare on resp_valid
    always @(negedge clock) begin
        if (bus.MemReadEn)
            rd_cnt <= rd_cnt + 1;
        if (bus.MemWriteEn) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_last <= bus.AddressBus;
            wr_data_last <= bus.DataMemoryInput;
        end
        if (bus.resp_valid) begin
            last_resp_cyc <= cyc;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=resp_valid required=no_response");
            end else begin
                exp_e = sb_q.pop_front();
                check({exp_e.name, "_rdata"}, bus.resp_rdata, exp_e.rdata);
                check({exp_e.name, "_err"}, {31'd0, bus.resp_err}, {31'd0, exp_e.err});
                check({exp_e.name, "_lat"}, 32'(cyc - accept_edge + 1), 32'(exp_e.lat));
            end
        end
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] w);
        @(negedge clock);
        pl_addr = a;
        pl_word = w;
        pl_en   = 1'b1;
        @(posedge clock);
        #1 pl_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input string name);
        exp_t e;
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout actual=0 required=1", name);
        end
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.name  = name;
        sb_q.push_back(e);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(negedge clock);
            #2;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_resp_timeout actual=no_resp required=resp_valid", name);
            sb_q.delete();
        end
    endtask

    int rd0;
    int wr0;
    int r_edge;

    initial begin
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_rd_en",      {31'd0, bus.MemReadEn},  32'd0);
        check("rst_wr_en",      {31'd0, bus.MemWriteEn}, 32'd0);
        check("rst_addr",       bus.AddressBus,          32'd0);
        check("rst_wdata",      bus.DataMemoryInput,     32'd0);
        check("rst_rdata",      bus.resp_rdata,          32'd0);
        rst = 1'b1;

        // T1/T2: loads with extension
        preload(10'h010, 32'hFF007F80);
        preload(10'h020, 32'h44332211);
        preload(10'h030, 32'hCAFEBABE);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 3, "LB_10");
        do_req(1'b0, 3'b100, 32'h10, 32'h0, 32'h00000080, 1'b0, 3, "LBU_10");
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 32'h00007F80, 1'b0, 3, "LH_10");
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000FF00, 1'b0, 3, "LHU_12");
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFFF00, 1'b0, 3, "LH_12");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hFF007F80, 1'b0, 3, "LW_10");

        // T3: SB/SH read-modify-write
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 3'b000, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, 4, "SB_20");
        check("SB_mem",      mem_word(10'h020), 32'h443322DD);
        check("SB_rd_count", 32'(rd_cnt - rd0), 32'd1);
        check("SB_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("SB_wr_data",  wr_data_last,      32'h443322DD);
        do_req(1'b1, 3'b001, 32'h20, 32'h12345678, 32'h0, 1'b0, 4, "SH_20");
        check("SH_mem",      mem_word(10'h020), 32'h44335678);

        // T4: SW at the top of the address space and masking
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 3'b010, 32'h3FE, 32'h01020304, 32'h0, 1'b0, 2, "SW_3FE");
        check("SW_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("SW_rd_count", 32'(rd_cnt - rd0), 32'd0);
        check("SW_wr_addr",  wr_addr_last,      32'h3FE);
        check("SW_wr_data",  wr_data_last,      32'h01020304);
        do_req(1'b1, 3'b010, 32'h7FE, 32'h0A0B0C0D, 32'h0, 1'b0, 2, "SW_7FE");
        check("SW_mask_addr", wr_addr_last, 32'h3FE);
        do_req(1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0A0B0C0D, 1'b0, 3, "LW_3FE");

        // T5: reset while an SH sits in WAIT
        wr0 = wr_cnt;
        @(negedge clock);
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h00001111;
        bus.req_valid  = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        check("T5_in_rd", {31'd0, bus.MemReadEn}, 32'd1);
        @(negedge clock);
        rst = 1'b0;
        #1;
        check("T5_rst_ready",  {31'd0, bus.req_ready},  32'd1);
        check("T5_rst_wr_en",  {31'd0, bus.MemWriteEn}, 32'd0);
        check("T5_rst_resp",   {31'd0, bus.resp_valid}, 32'd0);
        check("T5_rst_addr",   bus.AddressBus,          32'd0);
        @(negedge clock);
        rst = 1'b1;
        repeat (6) @(negedge clock);
        check("T5_wr_count", 32'(wr_cnt - wr0), 32'd0);
        check("T5_mem",      mem_word(10'h030), 32'hCAFEBABE);
        check("T5_ready",    {31'd0, bus.req_ready}, 32'd1);

        // T6: illegal requests, then back-to-back LW
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 3'b100, 32'h30, 32'h55, 32'h0, 1'b1, 1, "ILL_ST100");
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, "ILL_LD011");
        check("ILL_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("ILL_no_wr", 32'(wr_cnt - wr0), 32'd0);
        r_edge = last_resp_cyc;
        do_req(1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEBABE, 1'b0, 3, "LW_after_ill");
        check("b2b_accept_edge", 32'(accept_edge), 32'(r_edge + 2));

        repeat (3) @(negedge clock);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
